// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory port arbiter.
//   arb_state_t   : ownership state of the single RAM port
//   NOP_INSN      : instruction returned for a failed fetch
//   fetch_addr_ok : fetch address is word aligned and inside the RAM
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,  // fetch owns the RAM
        ST_DRAIN   = 2'd1,  // in-flight fetch completes, nothing new accepted
        ST_LOAD    = 2'd2,  // loader owns the RAM
        ST_RELEASE = 2'd3   // single hand-back cycle, ld_done pulses
    } arb_state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    // A fetch is serviceable when it is word aligned and no address bit
    // above the RAM's byte range is set.
    function automatic logic fetch_addr_ok(input logic [31:0] addr,
                                           input int unsigned addr_w);
        return (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
// Shares one single-port synchronous instruction RAM between the fetch stage
// and a program loader. The loader always wins; once it asks, the fetch stage
// is stalled, the in-flight read drains, and the loader owns the RAM until it
// drops ld_req.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   if_req/if_addr      : fetch request and byte address
//   if_ready            : fetch accepted this cycle
//   if_rvalid/if_rdata  : fetch response, one cycle after acceptance
//   if_err              : response is for a misaligned/out-of-range address
//   ld_req              : loader session request (held for the session)
//   ld_valid/ld_addr/ld_data : loader write word
//   ld_ready            : loader word accepted this cycle
//   ld_done             : one-cycle pulse when the session ends
//   ld_count            : words written in the current/last session
//   cpu_stall           : pipeline must hold its PC
//   mem_*               : external RAM port (read data one cycle after mem_en)
// -----------------------------------------------------------------------------
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              ld_req,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,

    output logic              cpu_stall,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // ld_count stops at the number of words the RAM holds.
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    arb_state_t        state_q, state_d;
    logic [ADDR_W:0]   count_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;

    logic              addr_ok;
    logic              fetch_accept;
    logic              write_accept;
    logic              session_start;

    assign addr_ok = fetch_addr_ok(if_addr, ADDR_W);

    // Next state and all port-side controls. Everything is gated by reset so
    // the outputs read zero throughout a reset cycle, not just after it.
    always_comb begin
        // NOTE: every output gets a default before the case; a path that
        // forgot one would otherwise infer a latch.
        state_d       = state_q;
        if_ready      = 1'b0;
        ld_ready      = 1'b0;
        ld_done       = 1'b0;
        cpu_stall     = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        fetch_accept  = 1'b0;
        write_accept  = 1'b0;
        session_start = 1'b0;

        if (!reset) begin
            unique case (state_q)
                ST_RUN: begin
                    if (ld_req) begin
                        // Loader wins a same-cycle collision.
                        state_d       = ST_DRAIN;
                        cpu_stall     = 1'b1;
                        session_start = 1'b1;
                    end else begin
                        if_ready     = if_req;
                        fetch_accept = if_req;
                        // A bad address is acknowledged but never touches
                        // the RAM; the NOP comes from the response path.
                        if (if_req && addr_ok) begin
                            mem_en   = 1'b1;
                            mem_addr = if_addr[ADDR_W+1:2];
                        end
                    end
                end

                ST_DRAIN: begin
                    cpu_stall = 1'b1;
                    state_d   = ST_LOAD;
                end

                ST_LOAD: begin
                    cpu_stall = 1'b1;
                    if (!ld_req) begin
                        // A word still on ld_valid here is not written.
                        state_d = ST_RELEASE;
                    end else if (ld_valid) begin
                        ld_ready     = 1'b1;
                        write_accept = 1'b1;
                        mem_en       = 1'b1;
                        mem_we       = 1'b1;
                        mem_addr     = ld_addr;
                        mem_wdata    = ld_data;
                    end
                end

                ST_RELEASE: begin
                    cpu_stall = 1'b1;
                    ld_done   = 1'b1;
                    state_d   = ST_RUN;
                end

                default: state_d = ST_RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Dropping rsp_valid_q discards any read still in flight.
            state_q     <= ST_RUN;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= fetch_accept;
            rsp_err_q   <= fetch_accept && !addr_ok;
            if (session_start) begin
                count_q <= '0;
            end else if (write_accept && (count_q != COUNT_MAX)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // The RAM's read data is only forwarded for a good fetch; errors and idle
    // cycles present the NOP so stale RAM output never leaks out.
    assign if_rvalid = rsp_valid_q;
    assign if_err    = rsp_err_q;
    assign if_rdata  = (rsp_valid_q && !rsp_err_q) ? mem_rdata : DATA_W'(NOP_INSN);
    assign ld_count  = count_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ready, if_rvalid, if_err;
    logic [DATA_W-1:0] if_rdata;
    logic              ld_req, ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready, ld_done;
    logic [ADDR_W:0]   ld_count;
    logic              cpu_stall;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ld_req(ld_req), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_count(ld_count),
        .cpu_stall(cpu_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // External single-port synchronous RAM.
    logic [DATA_W-1:0] ram [WORDS];
    logic [DATA_W-1:0] ram_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    // Reference model: expected RAM contents, expected response for the next
    // cycle, and words written in the current session.
    logic [DATA_W-1:0] ref_mem [WORDS];
    logic              exp_valid;
    logic              exp_err;
    logic [DATA_W-1:0] exp_data;
    int                model_count;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;

    always @(negedge clk) if (ld_done === 1'b1) done_pulses++;

    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic lreq,
                         input logic lvalid, input logic [ADDR_W-1:0] laddr,
                         input logic [DATA_W-1:0] ldata);
        if_req = ireq; if_addr = iaddr; ld_req = lreq;
        ld_valid = lvalid; ld_addr = laddr; ld_data = ldata;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic addr_good(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * WORDS);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'h4, 1'b1, 1'b1, 6'd3, 32'h1234_5678);
        tick(); tick();
        @(negedge clk);
        checks++; if ({if_ready, if_rvalid, if_err, ld_ready, ld_done, cpu_stall, mem_en, mem_we} !== 8'h00) begin errors++; $display("FAIL reset_flags: got %b want 00000000", {if_ready, if_rvalid, if_err, ld_ready, ld_done, cpu_stall, mem_en, mem_we}); end
        checks++; if (if_rdata !== '0) begin errors++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
        checks++; if (ld_count !== '0) begin errors++; $display("FAIL reset_ld_count: got %0d want 0", ld_count); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, (i < 3) ? addrs[i % 3] : 32'h0, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            if (i < 3) begin
                checks++; if (if_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ADDR_W'(i)) begin errors++; $display("FAIL b2b_issue[%0d]: got ready=%b en=%b we=%b addr=%0d want 1/1/0/%0d", i, if_ready, mem_en, mem_we, mem_addr, i); end
            end
            if (i > 0) begin
                checks++; if (if_rvalid !== 1'b1 || if_err !== 1'b0 || if_rdata !== ref_mem[i-1]) begin errors++; $display("FAIL b2b_resp[%0d]: got v=%b e=%b d=%h want 1/0/%h", i, if_rvalid, if_err, if_rdata, ref_mem[i-1]); end
            end
            tick();
        end
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got rvalid=%b want 0", if_rvalid); end
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        addrs[0] = 32'h2; addrs[1] = 32'h100; addrs[2] = 32'h8000_0000; addrs[3] = 32'hFC;
        for (int i = 0; i < 4; i++) begin
            logic good;
            good = addr_good(addrs[i]);
            drive(1'b1, addrs[i], 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            checks++; if (if_ready !== 1'b1 || mem_en !== good) begin errors++; $display("FAIL err_issue[%h]: got ready=%b en=%b want 1/%b", addrs[i], if_ready, mem_en, good); end
            tick();
            drive(1'b0, 32'h0, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            checks++; if (if_rvalid !== 1'b1 || if_err !== !good || if_rdata !== (good ? ref_mem[WORDS-1] : 32'h0)) begin errors++; $display("FAIL err_resp[%h]: got v=%b e=%b d=%h want 1/%b/%h", addrs[i], if_rvalid, if_err, if_rdata, !good, good ? ref_mem[WORDS-1] : 32'h0); end
            tick();
        end
    endtask

    task automatic test_collision();
        drive(1'b1, 32'h10, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (if_ready !== 1'b0 || cpu_stall !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL coll_run: got ready=%b stall=%b en=%b want 0/1/0", if_ready, cpu_stall, mem_en); end
        tick();
        drive(1'b1, 32'h10, 1'b1, 1'b1, 6'd9, 32'hA5A5_0009);
        @(negedge clk);
        checks++; if (if_ready !== 1'b0 || ld_ready !== 1'b0 || mem_en !== 1'b0 || cpu_stall !== 1'b1 || if_rvalid !== 1'b0 || ld_count !== '0) begin errors++; $display("FAIL coll_drain: got ready=%b ldr=%b en=%b stall=%b rv=%b cnt=%0d want 0/0/0/1/0/0", if_ready, ld_ready, mem_en, cpu_stall, if_rvalid, ld_count); end
        tick();
        @(negedge clk);
        checks++; if (ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd9 || cpu_stall !== 1'b1) begin errors++; $display("FAIL coll_load: got ldr=%b we=%b addr=%0d stall=%b want 1/1/9/1", ld_ready, mem_we, mem_addr, cpu_stall); end
        tick();
        ref_mem[9] = 32'hA5A5_0009;
        drive(1'b0, 32'h0, 1'b0, 1'b0, '0, '0);
        tick(); tick();
    endtask

    task automatic test_load_session();
        logic [ADDR_W-1:0] wa [3];
        logic [DATA_W-1:0] wd [3];
        int pulses0;
        wa[0] = 6'd5; wa[1] = 6'd6; wa[2] = 6'd5;
        wd[0] = 32'hDEAD_BEEF; wd[1] = $urandom; wd[2] = $urandom;
        pulses0 = done_pulses;
        drive(1'b0, 32'h0, 1'b1, 1'b0, '0, '0);
        tick();
        @(negedge clk);
        checks++; if (ld_count !== '0) begin errors++; $display("FAIL load_clear: got %0d want 0", ld_count); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1, wa[i], wd[i]);
            @(negedge clk);
            checks++; if (ld_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== wa[i] || mem_wdata !== wd[i] || ld_count !== ADDR_W'(i)) begin errors++; $display("FAIL load_write[%0d]: got r=%b en=%b we=%b a=%0d d=%h cnt=%0d want 1/1/1/%0d/%h/%0d", i, ld_ready, mem_en, mem_we, mem_addr, mem_wdata, ld_count, wa[i], wd[i], i); end
            tick();
            ref_mem[wa[i]] = wd[i];
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 6'd7, 32'hBAD0_BAD0);
        @(negedge clk);
        checks++; if (ld_ready !== 1'b0 || mem_en !== 1'b0 || ld_count !== 7'd3) begin errors++; $display("FAIL load_end: got r=%b en=%b cnt=%0d want 0/0/3", ld_ready, mem_en, ld_count); end
        tick();
        drive(1'b1, 32'h14, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (ld_done !== 1'b1 || if_ready !== 1'b0 || ld_ready !== 1'b0 || cpu_stall !== 1'b1) begin errors++; $display("FAIL load_release: got done=%b ifr=%b ldr=%b stall=%b want 1/0/0/1", ld_done, if_ready, ld_ready, cpu_stall); end
        tick();
        @(negedge clk);
        checks++; if (if_ready !== 1'b1 || cpu_stall !== 1'b0 || ld_count !== 7'd3) begin errors++; $display("FAIL load_resume: got ifr=%b stall=%b cnt=%0d want 1/0/3", if_ready, cpu_stall, ld_count); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== wd[2]) begin errors++; $display("FAIL load_readback: got v=%b d=%h want 1/%h", if_rvalid, if_rdata, wd[2]); end
        checks++; if (done_pulses - pulses0 !== 1) begin errors++; $display("FAIL load_done_pulses: got %0d want 1", done_pulses - pulses0); end
        tick();
    endtask

    task automatic test_reset_in_load();
        int pulses0;
        pulses0 = done_pulses;
        drive(1'b0, 32'h0, 1'b1, 1'b0, '0, '0);
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1, ADDR_W'(20 + i), 32'hC0DE_0000 + i);
            tick();
            ref_mem[20 + i] = 32'hC0DE_0000 + i;
        end
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, '0, '0);
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h50, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (ld_count !== '0 || cpu_stall !== 1'b0 || ld_done !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL rst_load: got cnt=%0d stall=%b done=%b ifr=%b want 0/0/0/1", ld_count, cpu_stall, ld_done, if_ready); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (if_rdata !== 32'hC0DE_0000 || done_pulses - pulses0 !== 0) begin errors++; $display("FAIL rst_load_after: got d=%h pulses=%0d want c0de0000/0", if_rdata, done_pulses - pulses0); end
        tick();
    endtask

    task automatic test_saturation();
        drive(1'b0, 32'h0, 1'b1, 1'b0, '0, '0);
        tick(); tick();
        for (int k = 0; k < WORDS + 6; k++) begin
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            a = ADDR_W'($urandom); d = $urandom;
            drive(1'b0, 32'h0, 1'b1, 1'b1, a, d);
            @(negedge clk);
            checks++; if (ld_count !== 7'((k < WORDS) ? k : WORDS)) begin errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", k, ld_count, (k < WORDS) ? k : WORDS); end
            tick();
            ref_mem[a] = d;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, '0, '0);
        tick(); tick();
        @(negedge clk);
        checks++; if (ld_count !== 7'(WORDS) || cpu_stall !== 1'b0) begin errors++; $display("FAIL sat_hold: got cnt=%0d stall=%b want %0d/0", ld_count, cpu_stall, WORDS); end
        model_count = WORDS;
        tick();
    endtask

    task automatic random_session();
        int n;
        logic iq;
        iq = $urandom_range(0, 1);
        drive(iq, 32'h0, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (if_ready !== 1'b0 || cpu_stall !== 1'b1 || if_rvalid !== exp_valid || (exp_valid && if_rdata !== exp_data)) begin errors++; $display("FAIL rs_start: got r=%b st=%b v=%b d=%h want 0/1/%b/%h", if_ready, cpu_stall, if_rvalid, if_rdata, exp_valid, exp_data); end
        tick();
        exp_valid = 1'b0; model_count = 0;
        @(negedge clk);
        checks++; if (if_rvalid !== 1'b0 || ld_count !== '0 || ld_ready !== 1'b0) begin errors++; $display("FAIL rs_drain: got v=%b cnt=%0d ldr=%b want 0/0/0", if_rvalid, ld_count, ld_ready); end
        tick();
        n = $urandom_range(1, 8);
        for (int k = 0; k < n; k++) begin
            logic lv;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            lv = $urandom_range(0, 1); a = ADDR_W'($urandom); d = $urandom;
            drive($urandom_range(0, 1), 32'h0, 1'b1, lv, a, d);
            @(negedge clk);
            checks++; if (ld_ready !== lv || mem_we !== lv || if_ready !== 1'b0 || ld_count !== 7'(model_count)) begin errors++; $display("FAIL rs_load[%0d]: got r=%b we=%b ifr=%b cnt=%0d want %b/%b/0/%0d", k, ld_ready, mem_we, if_ready, ld_count, lv, lv, model_count); end
            tick();
            if (lv) begin ref_mem[a] = d; if (model_count < WORDS) model_count++; end
        end
        drive(1'b0, 32'h0, 1'b0, $urandom_range(0, 1), ADDR_W'($urandom), $urandom);
        @(negedge clk);
        checks++; if (ld_ready !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL rs_end: got r=%b en=%b want 0/0", ld_ready, mem_en); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (ld_done !== 1'b1 || cpu_stall !== 1'b1 || ld_count !== 7'(model_count)) begin errors++; $display("FAIL rs_release: got done=%b st=%b cnt=%0d want 1/1/%0d", ld_done, cpu_stall, ld_count, model_count); end
        tick();
    endtask

    task automatic test_random();
        exp_valid = 1'b0; exp_err = 1'b0; exp_data = '0;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                random_session();
            end else begin
                logic ireq, good;
                logic [31:0] a;
                ireq = ($urandom_range(0, 3) != 0);
                a = ($urandom_range(0, 4) != 0) ? 32'($urandom_range(0, WORDS - 1) * 4) : $urandom;
                good = addr_good(a);
                drive(ireq, a, 1'b0, 1'b0, '0, '0);
                @(negedge clk);
                checks++; if (if_ready !== ireq || cpu_stall !== 1'b0 || mem_en !== (ireq && good) || ld_count !== 7'(model_count)) begin errors++; $display("FAIL rnd_issue[%0d]: got r=%b st=%b en=%b cnt=%0d want %b/0/%b/%0d", it, if_ready, cpu_stall, mem_en, ld_count, ireq, ireq && good, model_count); end
                checks++; if (if_rvalid !== exp_valid || (exp_valid && (if_err !== exp_err || if_rdata !== exp_data))) begin errors++; $display("FAIL rnd_resp[%0d]: got v=%b e=%b d=%h want %b/%b/%h", it, if_rvalid, if_err, if_rdata, exp_valid, exp_err, exp_data); end
                tick();
                exp_valid = ireq;
                exp_err   = ireq && !good;
                exp_data  = good ? ref_mem[a[ADDR_W+1:2]] : 32'h0;
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram[i]     = 32'h1000_0000 + 32'(i * 7);
            ref_mem[i] = 32'h1000_0000 + 32'(i * 7);
        end
        model_count = 0;
        exp_valid = 1'b0; exp_err = 1'b0; exp_data = '0;
        test_reset();
        test_back_to_back();
        test_errors();
        test_collision();
        test_load_session();
        test_reset_in_load();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
